// File: rtl/mem_arbiter_if.sv
// CPU / UART-loader request ports and the shared single-port RAM bus.
// The arbiter uses the slave view; requesters and the RAM model use master.
interface mem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;

    logic        dma_req;
    logic        dma_we;
    logic        dma_lock;
    logic [7:0]  dma_addr;
    logic [15:0] dma_wdata;
    logic        dma_ack;
    logic [15:0] dma_rdata;

    logic        ram_en;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    logic        owner;

    // Handshake: a requester raises req with operands stable and keeps them
    // until its ack; the arbiter samples them once in IDLE, and ack is a
    // single-cycle pulse with rdata valid in that cycle and held afterwards.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
        output dma_ack, dma_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata,
        output owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
        input  dma_ack, dma_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata,
        input  owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (CPU / UART-loader) arbiter in front of a single-port RAM.
// Define ROUND_ROBIN_EN for alternating tie-breaks; default is CPU-first priority.
module mem_arbiter (
    input  logic               clk,
    input  logic               reset,
    mem_arbiter_if.slave       bus,
    output logic [1:0]         dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    state_t      state_q, state_d;
    logic        win_q;
    logic        we_q;
    logic [7:0]  addr_q;
    logic [15:0] wdata_q;
    logic [15:0] cpu_rdata_q;
    logic [15:0] dma_rdata_q;
    logic        cpu_elig;
    logic        tie_to_dma;
    logic        pick_dma;
    logic        any_grant;

`ifdef ROUND_ROBIN_EN
    // Cleared by reset so the first tie afterwards goes to the CPU.
    logic        has_owner_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            has_owner_q <= 1'b0;
        end else if (state_q == IDLE && any_grant) begin
            has_owner_q <= 1'b1;
        end
    end

    assign tie_to_dma = has_owner_q && !win_q;
`else
    assign tie_to_dma = 1'b0;
`endif

    // win_q in IDLE is the last completed winner, so it doubles as the lock owner.
    assign cpu_elig  = bus.cpu_req && !(win_q && bus.dma_lock);
    assign pick_dma  = bus.dma_req && (!cpu_elig || tie_to_dma);
    assign any_grant = cpu_elig || bus.dma_req;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_grant) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            win_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 16'h0000;
            cpu_rdata_q <= 16'h0000;
            dma_rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any_grant) begin
                win_q   <= pick_dma;
                we_q    <= pick_dma ? bus.dma_we    : bus.cpu_we;
                addr_q  <= pick_dma ? bus.dma_addr  : bus.cpu_addr;
                wdata_q <= pick_dma ? bus.dma_wdata : bus.cpu_wdata;
            end
            if (state_q == RESP && !we_q) begin
                if (win_q) dma_rdata_q <= bus.ram_rdata;
                else       cpu_rdata_q <= bus.ram_rdata;
            end
        end
    end

    // Read data passes straight through during RESP, then the captured copy holds it.
    assign bus.cpu_rdata = (state_q == RESP && !win_q && !we_q) ? bus.ram_rdata : cpu_rdata_q;
    assign bus.dma_rdata = (state_q == RESP &&  win_q && !we_q) ? bus.ram_rdata : dma_rdata_q;
    assign bus.cpu_ack   = (state_q == RESP) && !win_q;
    assign bus.dma_ack   = (state_q == RESP) &&  win_q;
    assign bus.ram_en    = (state_q == ACCESS);
    assign bus.ram_we    = (state_q == ACCESS) && we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.owner     = win_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural RAM model.
module tb_mem_arbiter;
  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  int         n_cmp;
  int         n_bad;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single-port RAM: read data valid the cycle after an enabled read
  logic [15:0] mem [0:255];
  logic [15:0] ram_q;
  assign bus.ram_rdata = ram_q;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_q <= 16'h0000;
    end else if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            ram_q <= mem[bus.ram_addr];
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h00; bus.cpu_wdata = 16'h0000;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_lock = 1'b0;
    bus.dma_addr = 8'h00; bus.dma_wdata = 16'h0000;
  endtask

  // Wait (bounded) for the next ack; who = 0 for CPU, 1 for DMA.
  task automatic wait_grant(input string tag, output logic who);
    logic found;
    found = 1'b0;
    who   = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (bus.cpu_ack || bus.dma_ack) begin
        found = 1'b1;
        who   = bus.dma_ack;
        check({tag, "_one_ack"}, 16'(bus.cpu_ack & bus.dma_ack), 16'h0);
      end
    end
    if (!found) check({tag, "_timeout"}, 16'h0, 16'h1);
  endtask

  // CPU access from IDLE with exact-cycle latency checks; called at a negedge.
  task automatic cpu_op(input string tag, input logic we, input logic [7:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rd);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    @(negedge clk);
    check({tag, "_ram_en"},   16'(bus.ram_en), 16'h1);
    check({tag, "_ram_we"},   16'(bus.ram_we), 16'(we));
    check({tag, "_ram_addr"}, 16'(bus.ram_addr), 16'(addr));
    if (we) check({tag, "_ram_wdata"}, bus.ram_wdata, wdata);
    check({tag, "_early_ack"}, 16'(bus.cpu_ack), 16'h0);
    @(negedge clk);
    check({tag, "_cpu_ack"}, 16'(bus.cpu_ack), 16'h1);
    check({tag, "_dma_ack"}, 16'(bus.dma_ack), 16'h0);
    check({tag, "_en_off"},  16'(bus.ram_en), 16'h0);
    if (!we) check({tag, "_rdata"}, bus.cpu_rdata, exp_rd);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    check({tag, "_ack_drop"}, 16'(bus.cpu_ack), 16'h0);
    if (!we) check({tag, "_rdata_hold"}, bus.cpu_rdata, exp_rd);
  endtask

  logic                  who;
  logic                  exp_who;
  logic [15:0]           exp_q [$];
  int                    ack_cnt;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_ram_en",    16'(bus.ram_en), 16'h0);
    check("rst_ram_we",    16'(bus.ram_we), 16'h0);
    check("rst_ram_addr",  16'(bus.ram_addr), 16'h0);
    check("rst_ram_wdata", bus.ram_wdata, 16'h0);
    check("rst_acks",      16'({bus.cpu_ack, bus.dma_ack}), 16'h0);
    check("rst_cpu_rdata", bus.cpu_rdata, 16'h0);
    check("rst_dma_rdata", bus.dma_rdata, 16'h0);
    check("rst_owner",     16'(bus.owner), 16'h0);
    check("rst_state",     16'(dbg_state), 16'h0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_no_req", 16'(bus.ram_en), 16'h0);

    // simultaneous requests, first tie after reset
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h30; bus.cpu_wdata = 16'h1111;
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 8'h31; bus.dma_wdata = 16'h2222;
`ifdef ROUND_ROBIN_EN
    exp_q = '{16'h0, 16'h1, 16'h0};
`else
    exp_q = '{16'h0, 16'h0, 16'h0};
`endif
    for (int g = 0; g < 3; g++) begin
      wait_grant("tie", who);
      exp_who = exp_q.pop_front()[0];
      check($sformatf("tie_grant%0d", g), 16'(who), 16'(exp_who));
    end
    idle_inputs();
    @(negedge clk);

    // write then read back through the CPU port
    cpu_op("cpu_wr", 1'b1, 8'h10, 16'h1234, 16'h0000);
    cpu_op("cpu_rd", 1'b0, 8'h10, 16'h0000, 16'h1234);
    cpu_op("cpu_ff", 1'b0, 8'h30, 16'h0000, 16'h1111);

    // single-cycle request pulse
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h10;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    check("pulse_access", 16'(bus.ram_en), 16'h1);
    @(negedge clk);
    check("pulse_ack",   16'(bus.cpu_ack), 16'h1);
    check("pulse_rdata", bus.cpu_rdata, 16'h1234);
    ack_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.cpu_ack) ack_cnt++;
    end
    check("pulse_extra_acks", 16'(ack_cnt), 16'h0);

    // DMA lock holds off a waiting CPU
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 8'hFF;
    bus.dma_wdata = 16'hAAAA; bus.dma_lock = 1'b1;
    wait_grant("lock0", who);
    check("lock0_who", 16'(who), 16'h1);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'hFF;
    wait_grant("lock1", who);
    check("lock1_who", 16'(who), 16'h1);
    wait_grant("lock2", who);
    check("lock2_who", 16'(who), 16'h1);
    check("lock_owner", 16'(bus.owner), 16'h1);
    bus.dma_lock = 1'b0;
    wait_grant("unlock", who);
    check("unlock_who",   16'(who), 16'h0);
    check("unlock_rdata", bus.cpu_rdata, 16'hAAAA);
    check("unlock_owner", 16'(bus.owner), 16'h0);
    idle_inputs();
    @(negedge clk);

    // reset during a DMA write aborts it
    cpu_op("old_wr", 1'b1, 8'h20, 16'h5555, 16'h0000);
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 8'h20; bus.dma_wdata = 16'h9999;
    @(negedge clk);
    check("abort_in_access", 16'(bus.ram_en), 16'h1);
    #2 reset = 1'b0;
    #1;
    check("abort_en_drop", 16'(bus.ram_en), 16'h0);
    check("abort_we_drop", 16'(bus.ram_we), 16'h0);
    check("abort_state",   16'(dbg_state), 16'h0);
    bus.dma_req = 1'b0;
    ack_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.dma_ack) ack_cnt++;
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.dma_ack) ack_cnt++;
    end
    check("abort_no_ack", 16'(ack_cnt), 16'h0);
    cpu_op("abort_rd", 1'b0, 8'h20, 16'h0000, 16'h5555);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
